// File: rtl/simd_job_sequencer.sv
// simd_job_sequencer: job-level controller that streams operand pairs through the SIMD unit
// and returns results in order through a credit-limited result FIFO.
module simd_job_sequencer #(
   parameter int LEN_W = 16,
   parameter int LAT   = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic [1:0]       cfg_mode,
   input  logic [31:0]      cfg_param,
   input  logic [LEN_W-1:0] cfg_len,
   output logic             busy,
   output logic             done,
   output logic             err_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_rs1,
   input  logic [31:0]      in_rs2,
   output logic [1:0]       simd_mode,
   output logic [31:0]      simd_param,
   output logic [31:0]      simd_rs1,
   output logic [31:0]      simd_rs2,
   input  logic [31:0]      simd_rd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [LAT:0]     fl_q, fl_d;
   logic [CW-1:0]    cnt_q, cnt_d, inflight;
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic [1:0]       mode_q, mode_d;
   logic [31:0]      param_q, param_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic             err_q, err_d;
   logic             start_ok, issue, push, pop, credit;

   always_comb begin
      inflight = '0;
      for (int i = 0; i <= LAT; i++) inflight = inflight + CW'(fl_q[i]);
   end

   // Every issued word holds a credit until it leaves the FIFO, so the FIFO cannot overflow.
   assign credit   = ({1'b0, cnt_q} + {1'b0, inflight}) < (CW+1)'(DEPTH);
   assign start_ok = state_q == IDLE && cfg_start && cfg_mode != 2'b11;
   assign issue    = in_valid && in_ready;
   assign push     = fl_q[LAT];
   assign pop      = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = cfg_len == '0 ? DONE : RUN;
         RUN:     if (issue && rem_q == LEN_W'(1)) state_d = DRAIN;
         DRAIN:   if (inflight == '0 && cnt_d == '0) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = state_q == RUN || state_q == DRAIN;
      done      = state_q == DONE;
      in_ready  = state_q == RUN && rem_q != '0 && credit;
      out_valid = cnt_q != '0;
      out_data  = out_valid ? mem_q[rp_q] : '0;
   end

   always_comb begin
      rem_d   = rem_q;
      mode_d  = mode_q;
      param_d = param_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      err_d   = err_q;
      if (state_q == IDLE && cfg_start && cfg_mode == 2'b11) err_d = 1'b1;
      if (start_ok && cfg_len != '0) begin
         rem_d   = cfg_len;
         mode_d  = cfg_mode;
         param_d = cfg_param;
         err_d   = 1'b0;
      end
      if (issue) begin
         rem_d = rem_q - LEN_W'(1);
         rs1_d = in_rs1;
         rs2_d = in_rs2;
      end
      fl_d  = {fl_q[LAT-1:0], issue};
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      mem_d = mem_q;
      if (push) mem_d[wp_q] = simd_rd;
      wp_d = push ? (wp_q == AW'(DEPTH - 1) ? '0 : wp_q + AW'(1)) : wp_q;
      rp_d = pop  ? (rp_q == AW'(DEPTH - 1) ? '0 : rp_q + AW'(1)) : rp_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rem_q   <= '0;
         fl_q    <= '0;
         cnt_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         mode_q  <= '0;
         param_q <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rem_q   <= rem_d;
         fl_q    <= fl_d;
         cnt_q   <= cnt_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         mode_q  <= mode_d;
         param_q <= param_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         err_q   <= err_d;
         mem_q   <= mem_d;
      end

   assign simd_mode  = mode_q;
   assign simd_param = param_q;
   assign simd_rs1   = rs1_q;
   assign simd_rs2   = rs2_q;
   assign err_mode   = err_q;
endmodule

// File: tb/tb_simd_job_sequencer.sv
// tb_simd_job_sequencer: randomized jobs checked cycle by cycle against a queue-based job model.
module tb_simd_job_sequencer;
   localparam int LEN_W = 16, LAT = 1, DEPTH = 4;

   logic             clk = 0, rst_n = 0;
   logic             cfg_start = 0;
   logic [1:0]       cfg_mode = 0;
   logic [31:0]      cfg_param = 0;
   logic [LEN_W-1:0] cfg_len = 0;
   logic             busy, done, err_mode, in_ready, out_valid;
   logic             in_valid = 0, out_ready = 0;
   logic [31:0]      in_rs1 = 0, in_rs2 = 0;
   logic [1:0]       simd_mode;
   logic [31:0]      simd_param, simd_rs1, simd_rs2, simd_rd, out_data;
   logic [31:0]      pipe [LAT];

   int n_chk = 0, n_err = 0;
   int n_hs = 0, n_pop = 0, n_done = 0;
   logic [31:0] last_pop = 0;

   typedef enum {P_IDLE, P_ACT, P_DONE} ph_t;
   ph_t         m_ph = P_IDLE;
   int          m_rem = 0, t = 0;
   logic        m_err = 0, exp_ir, exp_ov;
   logic [1:0]  m_mode = 0;
   logic [31:0] m_param = 0, m_rs1 = 0, m_rs2 = 0;
   logic [31:0] eq_d [$];
   int          eq_t [$];

   simd_job_sequencer #(.LEN_W(LEN_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
      .cfg_param(cfg_param), .cfg_len(cfg_len), .busy(busy), .done(done),
      .err_mode(err_mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .simd_mode(simd_mode),
      .simd_param(simd_param), .simd_rs1(simd_rs1), .simd_rs2(simd_rs2),
      .simd_rd(simd_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data));

   always #5 clk = ~clk;

   // Pixel ops per 8-bit lane: blend, invert, saturating brightness.
   function automatic logic [31:0] simd_f(input logic [1:0] m, input logic [31:0] p,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) begin
         int ai, bi, pi, x;
         ai = int'(a[8*i +: 8]);
         bi = int'(b[8*i +: 8]);
         pi = int'(p[8*i +: 8]);
         x = m == 2'd0 ? (ai * pi + bi * (256 - pi)) >> 8 :
             m == 2'd1 ? 255 - ai :
             m == 2'd2 ? (ai + pi > 255 ? 255 : ai + pi) : 0;
         r[8*i +: 8] = 8'(x);
      end
      return r;
   endfunction

   // Stand-in SIMD unit with LAT register stages; never reset, so stale results linger.
   always @(posedge clk) begin
      pipe[0] <= simd_f(simd_mode, simd_param, simd_rs1, simd_rs2);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign simd_rd = pipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         m_ph = P_IDLE; m_rem = 0; m_err = 0; m_mode = 0; m_param = 0;
         m_rs1 = 0; m_rs2 = 0; t = 0;
         eq_d.delete(); eq_t.delete();
         chk("rst_ctl", 32'({busy, done, err_mode, in_ready, out_valid, simd_mode}), 0);
         chk("rst_param", simd_param, 0);
         chk("rst_rs1", simd_rs1, 0);
         chk("rst_rs2", simd_rs2, 0);
         chk("rst_out_data", out_data, 0);
      end else begin
         exp_ir = m_ph == P_ACT && m_rem != 0 && eq_d.size() < DEPTH;
         exp_ov = eq_d.size() != 0 && eq_t[0] <= t;
         chk("busy", busy, m_ph == P_ACT);
         chk("done", done, m_ph == P_DONE);
         chk("in_ready", in_ready, exp_ir);
         chk("out_valid", out_valid, exp_ov);
         if (exp_ov) chk("out_data", out_data, eq_d[0]);
         chk("err_mode", err_mode, m_err);
         chk("simd_mode", simd_mode, m_mode);
         chk("simd_param", simd_param, m_param);
         chk("simd_rs1", simd_rs1, m_rs1);
         chk("simd_rs2", simd_rs2, m_rs2);
         if (in_valid && in_ready) n_hs++;
         if (out_valid && out_ready) begin n_pop++; last_pop = out_data; end
         if (done) n_done++;
         if (m_ph == P_DONE) m_ph = P_IDLE;
         else if (m_ph == P_IDLE) begin
            if (cfg_start && cfg_mode == 2'b11) m_err = 1;
            else if (cfg_start && cfg_len == 0) m_ph = P_DONE;
            else if (cfg_start) begin
               m_ph = P_ACT; m_rem = int'(cfg_len); m_err = 0;
               m_mode = cfg_mode; m_param = cfg_param;
            end
         end else begin
            if (in_valid && exp_ir) begin
               eq_d.push_back(simd_f(m_mode, m_param, in_rs1, in_rs2));
               eq_t.push_back(t + 2 + LAT);
               m_rem--; m_rs1 = in_rs1; m_rs2 = in_rs2;
            end
            if (exp_ov && out_ready) begin
               void'(eq_d.pop_front());
               void'(eq_t.pop_front());
            end
            if (m_rem == 0 && eq_d.size() == 0) m_ph = P_DONE;
         end
         t++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cfg_start = 0; in_valid = 0; out_ready = 0;
   endtask

   task automatic run(input logic [1:0] mode, input logic [31:0] param, input int len,
                      input logic [31:0] rs1, input logic [31:0] rs2, input bit rnd,
                      input int vp, input int rp, input int hold, input int abort_at,
                      output int acc_hold);
      int hs0, p0, d0;
      step();
      cfg_start = 1; cfg_mode = mode; cfg_param = param; cfg_len = LEN_W'(len);
      step();
      cfg_start = 0;
      hs0 = n_hs; p0 = n_pop; d0 = n_done; acc_hold = -1;
      for (int c = 0; c < 3000 && n_done == d0; c++) begin
         if (c == hold) acc_hold = n_hs - hs0;
         if (abort_at > 0 && n_hs - hs0 >= abort_at) begin
            chk("abort_pre_valid", out_valid, 1);
            rst_n = 0;
            #1;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            break;
         end
         in_valid  = $urandom_range(99) < vp;
         in_rs1    = rnd ? $urandom : rs1;
         in_rs2    = rnd ? $urandom : rs2;
         out_ready = c >= hold && $urandom_range(99) < rp;
         cfg_start = busy && $urandom_range(7) == 0;
         cfg_mode  = 2'($urandom);
         cfg_param = $urandom;
         cfg_len   = LEN_W'($urandom);
         step();
      end
      idle();
      if (abort_at == 0) begin
         chk("job_done", n_done != d0, 1);
         repeat (3) step();
         chk("done_once", n_done - d0, 1);
         chk("pops", n_pop - p0, len);
      end
   endtask

   initial begin
      int ah;
      for (int i = 0; i < 5; i++) begin
         step();
         cfg_start = 1'($urandom); cfg_mode = 2'($urandom); cfg_param = $urandom;
         cfg_len = LEN_W'($urandom); in_valid = 1'($urandom); in_rs1 = $urandom;
         in_rs2 = $urandom; out_ready = 1'($urandom);
      end
      idle();
      rst_n = 1;
      repeat (3) step();
      chk("post_rst_ready", in_ready, 0);
      chk("post_rst_busy", busy, 0);

      run(2'd0, 32'h80808080, 1, 32'h64646464, 32'hC8C8C8C8, 0, 100, 100, 0, 0, ah);
      chk("blend_data", last_pop, 32'h96969696);

      run(2'd1, 32'h0, 8, 32'h00FF64C8, 32'h0, 0, 100, 100, 20, 0, ah);
      chk("credit_stall", ah, DEPTH);
      chk("invert_data", last_pop, 32'hFF009B37);

      run(2'd2, 32'h640A640A, 5, 32'hC8C8C8C8, 32'h0, 0, 60, 50, 0, 0, ah);
      chk("bright_data", last_pop, 32'hFFD2FFD2);

      run(2'd1, 32'h0, 0, 32'h0, 32'h0, 0, 100, 100, 0, 0, ah);

      step();
      cfg_start = 1; cfg_mode = 2'b11; cfg_len = 5;
      step();
      cfg_start = 0;
      step();
      chk("err_set", err_mode, 1);
      chk("err_busy", busy, 0);
      run(2'd0, $urandom, 3, 0, 0, 1, 80, 80, 0, 0, ah);
      chk("err_clear", err_mode, 0);

      run(2'd0, $urandom, 6, 0, 0, 1, 100, 100, 100, 3, ah);
      repeat (2) step();
      rst_n = 1;
      repeat (2) step();
      chk("abort_idle_valid", out_valid, 0);
      run(2'd0, $urandom, 2, 0, 0, 1, 100, 100, 0, 0, ah);

      for (int j = 0; j < 10; j++)
         run(2'($urandom_range(2)), $urandom, $urandom_range(1, 12), 0, 0, 1, 70, 60,
             $urandom_range(0, 6), 0, ah);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
